// File: rtl/mod_updown_counter.sv
// Modulo-MOD synchronous up/down counter with a one-cycle wrap pulse,
// a sticky overflow flag and a sticky out-of-range load flag.
module mod_updown_counter #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned MOD   = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] din,
    input  logic             en,
    input  logic             up_dn,
    output logic [WIDTH-1:0] q,
    output logic             wrap,
    output logic             ovf,
    output logic             ld_err
);

    localparam int unsigned    WW    = WIDTH + 1;
    localparam logic [WW-1:0]  MOD_W = WW'(MOD);
    localparam logic [WIDTH-1:0] MAX = WIDTH'(MOD - 1);

    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic             wrap_q, wrap_d;
    logic             ovf_q, ovf_d;
    logic             err_q, err_d;

    logic [WW-1:0]    inc_c;
    logic [WIDTH-1:0] dec_c;
    logic             din_ok_c;

    // Increment is one bit wider so MOD = 2^WIDTH never truncates before the compare.
    assign inc_c    = {1'b0, cnt_q} + WW'(1);
    assign dec_c    = cnt_q - WIDTH'(1);
    assign din_ok_c = ({1'b0, din} < MOD_W);

    // Next-state logic; priority clr > load > en > hold.
    always_comb begin
        cnt_d  = cnt_q;
        wrap_d = 1'b0;
        ovf_d  = ovf_q;
        err_d  = err_q;
        if (clr) begin
            cnt_d = '0;
            ovf_d = 1'b0;
            err_d = 1'b0;
        end else if (load) begin
            if (din_ok_c) begin
                cnt_d = din;
            end else begin
                cnt_d = MAX;
                err_d = 1'b1;
            end
        end else if (en) begin
            if (up_dn) begin
                if (cnt_q == MAX) begin
                    cnt_d  = '0;
                    wrap_d = 1'b1;
                    ovf_d  = 1'b1;
                end else begin
                    cnt_d = WIDTH'(inc_c);
                end
            end else begin
                if (cnt_q == '0) begin
                    cnt_d  = MAX;
                    wrap_d = 1'b1;
                    ovf_d  = 1'b1;
                end else begin
                    cnt_d = dec_c;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            wrap_q <= 1'b0;
            ovf_q  <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            wrap_q <= wrap_d;
            ovf_q  <= ovf_d;
            err_q  <= err_d;
        end
    end

    assign q      = cnt_q;
    assign wrap   = wrap_q;
    assign ovf    = ovf_q;
    assign ld_err = err_q;

endmodule

// File: tb/tb_mod_updown_counter.sv
// Directed bench for mod_updown_counter: a modulus-10 instance and a
// full-range modulus-16 instance, checked against hand-computed values.
module tb_mod_updown_counter;

    logic       clk;
    logic       rst_n;
    logic       a_clr, a_load, a_en, a_up;
    logic [3:0] a_din;
    logic [3:0] a_q;
    logic       a_wrap, a_ovf, a_err;
    logic       b_clr, b_load, b_en, b_up;
    logic [3:0] b_din;
    logic [3:0] b_q;
    logic       b_wrap, b_ovf, b_err;

    int total = 0;
    int bad   = 0;

    mod_updown_counter #(.WIDTH(4), .MOD(10)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .clr(a_clr), .load(a_load), .din(a_din),
        .en(a_en), .up_dn(a_up), .q(a_q), .wrap(a_wrap), .ovf(a_ovf), .ld_err(a_err)
    );

    mod_updown_counter #(.WIDTH(4), .MOD(16)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .clr(b_clr), .load(b_load), .din(b_din),
        .en(b_en), .up_dn(b_up), .q(b_q), .wrap(b_wrap), .ovf(b_ovf), .ld_err(b_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input int unsigned got, input int unsigned exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic a_set(input logic clr_v, input logic load_v, input logic [3:0] din_v,
                         input logic en_v, input logic up_v);
        a_clr = clr_v; a_load = load_v; a_din = din_v; a_en = en_v; a_up = up_v;
    endtask

    task automatic a_all(input string tag, input int unsigned eq, input int unsigned ew,
                         input int unsigned eo, input int unsigned ee);
        chk({tag, ".q"},      a_q,    eq);
        chk({tag, ".wrap"},   a_wrap, ew);
        chk({tag, ".ovf"},    a_ovf,  eo);
        chk({tag, ".ld_err"}, a_err,  ee);
    endtask

    initial begin
        rst_n = 1'b0;
        a_set(0, 0, 4'd0, 0, 1);
        b_clr = 0; b_load = 0; b_din = 4'd0; b_en = 0; b_up = 1;
        tick();
        tick();
        a_all("reset", 0, 0, 0, 0);
        rst_n = 1'b1;

        // Out-of-range load, then count up through a wrap to reach q=7.
        a_set(0, 1, 4'd12, 0, 1);
        tick();
        a_all("load12_pre", 9, 0, 0, 1);
        a_set(0, 0, 4'd0, 1, 1);
        tick();
        a_all("pre_wrap", 0, 1, 1, 1);
        for (int i = 1; i <= 7; i++) tick();
        chk("pre_q7", a_q, 7);

        // Asynchronous reset mid-cycle clears everything before the next edge.
        #3 rst_n = 1'b0;
        #1;
        a_all("async_rst", 0, 0, 0, 0);
        #2 rst_n = 1'b1;
        a_set(0, 0, 4'd0, 0, 1);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("hold_q", a_q, 0);
        end

        // Up count through the MOD=10 boundary.
        a_set(0, 0, 4'd0, 1, 1);
        for (int i = 1; i <= 12; i++) begin
            tick();
            chk("up_q",    a_q,    i % 10);
            chk("up_wrap", a_wrap, (i == 10) ? 1 : 0);
            chk("up_ovf",  a_ovf,  (i >= 10) ? 1 : 0);
        end
        a_set(0, 0, 4'd0, 0, 0);
        tick();
        a_all("hold_after_up", 2, 0, 1, 0);

        a_set(0, 1, 4'd5, 0, 1);
        tick();
        a_all("load5", 5, 0, 1, 0);

        // Down count through zero.
        a_set(0, 1, 4'd2, 0, 0);
        tick();
        chk("load2_q", a_q, 2);
        a_set(0, 0, 4'd0, 1, 0);
        tick(); chk("dn1_q", a_q, 1); chk("dn1_wrap", a_wrap, 0);
        tick(); chk("dn0_q", a_q, 0); chk("dn0_wrap", a_wrap, 0);
        tick(); chk("dn9_q", a_q, 9); chk("dn9_wrap", a_wrap, 1);
        tick(); chk("dn8_q", a_q, 8); chk("dn8_wrap", a_wrap, 0);

        a_set(0, 1, 4'd12, 0, 1);
        tick();
        a_all("load12", 9, 0, 1, 1);
        a_set(1, 0, 4'd0, 0, 1);
        tick();
        a_all("clr", 0, 0, 0, 0);

        // Priority: clr beats load and en; load beats en.
        a_set(1, 1, 4'd3, 1, 1);
        tick();
        chk("clr_wins_q", a_q, 0);
        a_set(0, 1, 4'd3, 1, 1);
        tick();
        a_all("load_wins", 3, 0, 0, 0);

        // Direction reversal at the zero boundary.
        a_set(0, 1, 4'd0, 0, 1);
        tick();
        a_set(0, 0, 4'd0, 1, 0);
        tick();
        a_all("rev_dn", 9, 1, 1, 0);
        a_set(0, 0, 4'd0, 1, 1);
        tick();
        a_all("rev_up", 0, 1, 1, 0);

        // Reset while a wrap pulse is visible.
        #3 rst_n = 1'b0;
        #1;
        a_all("rst_wrap", 0, 0, 0, 0);
        #2 rst_n = 1'b1;
        a_set(0, 0, 4'd0, 0, 1);

        // Full-range MOD=16 instance.
        b_load = 1; b_din = 4'd15;
        tick();
        chk("b_load15_q", b_q, 15);
        chk("b_load15_err", b_err, 0);
        b_load = 0; b_en = 1; b_up = 1;
        tick();
        chk("b_up_q", b_q, 0);
        chk("b_up_wrap", b_wrap, 1);
        chk("b_up_ovf", b_ovf, 1);
        b_up = 0;
        tick();
        chk("b_dn_q", b_q, 15);
        chk("b_dn_wrap", b_wrap, 1);
        tick();
        chk("b_dn14_q", b_q, 14);
        chk("b_dn14_wrap", b_wrap, 0);
        b_en = 0;
        chk("a_idle_q", a_q, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
